// File: rtl/n64_controller_top_spec.sv
// N64 joybus host: register file, TX/RX FIFOs and a bit-timing FSM
// driving one of four open-drain controller lines.
module n64_controller_top_spec #(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       reset_l,
  inout  wire        joy1,
  inout  wire        joy2,
  inout  wire        joy3,
  inout  wire        joy4,
  input  logic [3:0] address,
  input  logic [7:0] data_in_bus,
  input  logic       write,
  input  logic       ce,
  output logic [7:0] data_out_bus
);

  localparam int TW = 16;
  localparam logic [TW-1:0] T1  = TW'(CLKS_PER_US);
  localparam logic [TW-1:0] T2  = TW'(2 * CLKS_PER_US);
  localparam logic [TW-1:0] T3  = TW'(3 * CLKS_PER_US);
  localparam logic [TW-1:0] T4  = TW'(4 * CLKS_PER_US);
  localparam logic [TW-1:0] TMO = TW'(64 * CLKS_PER_US);

  typedef enum logic [2:0] {
    IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d, ahi_q, ahi_d;
  logic [7:0]    alo_q, alo_d, ctrl_q, ctrl_d;
  logic [3:0]    sel_q, sel_d, sel_new;
  logic [3:0]    sync1_q, sync1_d, sync2_q;
  logic          done_q, done_d, tmo_q, tmo_d;
  logic          prev_q, smp_q, smp_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [5:0]    idx_q, idx_d;
  logic [7:0]    txb_q, txb_d, rxb_q, rxb_d;
  logic [7:0]    dout_q, dout_d;
  logic [8:0]    rxn_q, rxn_d;
  logic [7:0]    tx_mem_q [32];
  logic [7:0]    rx_mem_q [64];
  logic [4:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [5:0]    tx_cnt_q, tx_cnt_d;
  logic [5:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [6:0]    rx_cnt_q, rx_cnt_d;

  logic [2:0] a;
  logic       wr, rd, clr, start, tmo_set;
  logic       tx_push, tx_pop, rx_push, rx_wen, rx_pop;
  logic       line, drive, busy, tx_full, rx_full, rx_empty;
  logic       unused_addr;
  logic [5:0] rx_len, tx_last;
  logic [7:0] rx_byte;
  logic [3:0] oe;

  assign a           = address[2:0];
  assign unused_addr = address[3];
  assign wr          = ce & write;
  assign rd          = ce & ~write;
  assign clr         = wr & (a == 3'd7);
  assign tx_full     = tx_cnt_q == 6'd32;
  assign rx_full     = rx_cnt_q == 7'd64;
  assign rx_empty    = rx_cnt_q == 7'd0;
  assign tx_push     = wr & (a == 3'd6) & ~tx_full;
  assign rx_pop      = rd & (a == 3'd6) & ~rx_empty;
  assign rx_wen      = rx_push & ~rx_full;
  assign line        = |(sync2_q & sel_q);
  assign rx_byte     = {rxb_q[6:0], line};
  assign busy        = state_q != IDLE;
  assign sync1_d     = {joy4, joy3, joy2, joy1};

  always_comb begin
    sel_new = 4'b0000;
    priority case (1'b1)
      data_in_bus[0]: sel_new = 4'b0001;
      data_in_bus[1]: sel_new = 4'b0010;
      data_in_bus[2]: sel_new = 4'b0100;
      data_in_bus[3]: sel_new = 4'b1000;
      default:        sel_new = 4'b0000;
    endcase
  end

  always_comb begin
    case (cmd_q)
      8'h00, 8'hFF: rx_len = 6'd3;
      8'h01:        rx_len = 6'd4;
      8'h02:        rx_len = 6'd33;
      8'h03:        rx_len = 6'd1;
      default:      rx_len = 6'd0;
    endcase
    case (cmd_q)
      8'h02:   tx_last = 6'd2;
      8'h03:   tx_last = 6'd34;
      default: tx_last = 6'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    txb_d   = txb_q;
    rxb_d   = rxb_q;
    rxn_d   = rxn_q;
    smp_d   = smp_q;
    sel_d   = sel_q;
    start   = 1'b0;
    tmo_set = 1'b0;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state_q)
      IDLE: if (wr && a == 3'd4 && sel_new != 4'b0000) begin
        start   = 1'b1;
        state_d = TX_BIT;
        tmr_d   = '0;
        bit_d   = 3'd7;
        idx_d   = '0;
        txb_d   = cmd_q;
        sel_d   = sel_new;
      end
      TX_BIT: if (tmr_q != T4 - 1'b1) begin
        tmr_d = tmr_q + 1'b1;
      end else begin
        tmr_d = '0;
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
          if (idx_q == tx_last) begin
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 6'd1;
            if (idx_q == 6'd0) begin
              txb_d = ahi_q;
            end else if (idx_q == 6'd1) begin
              txb_d = alo_q;
            end else begin
              // Payload underrun is padded with zero bytes
              tx_pop = tx_cnt_q != 6'd0;
              txb_d  = tx_pop ? tx_mem_q[tx_rp_q] : 8'h00;
            end
          end
        end
      end
      TX_STOP: if (tmr_q != T3 - 1'b1) begin
        tmr_d = tmr_q + 1'b1;
      end else begin
        tmr_d   = '0;
        rxn_d   = {rx_len, 3'b000};
        state_d = (rx_len == 6'd0) ? DONE : RX_WAIT;
      end
      RX_WAIT: if (prev_q && !line) begin
        state_d = RX_BIT;
        tmr_d   = '0;
        smp_d   = 1'b0;
      end else if (tmr_q == TMO - 1'b1) begin
        tmo_set = 1'b1;
        state_d = DONE;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      RX_BIT: if (!smp_q) begin
        if (tmr_q != T2 - 1'b1) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          smp_d   = 1'b1;
          rxb_d   = rx_byte;
          rxn_d   = rxn_q - 9'd1;
          rx_push = rxn_q[2:0] == 3'd1;
        end
      end else if (line) begin
        tmr_d   = '0;
        state_d = (rxn_q == 9'd0) ? DONE : RX_WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drive = 1'b0;
    unique case (state_q)
      TX_BIT:  drive = tmr_q < (txb_q[bit_q] ? T1 : T3);
      TX_STOP: drive = tmr_q < T1;
      default: drive = 1'b0;
    endcase
  end

  assign oe   = {4{drive}} & sel_q;
  assign joy1 = oe[0] ? 1'b0 : 1'bz;
  assign joy2 = oe[1] ? 1'b0 : 1'bz;
  assign joy3 = oe[2] ? 1'b0 : 1'bz;
  assign joy4 = oe[3] ? 1'b0 : 1'bz;

  always_comb begin
    cmd_d  = cmd_q;
    ahi_d  = ahi_q;
    alo_d  = alo_q;
    ctrl_d = ctrl_q;
    done_d = done_q;
    tmo_d  = tmo_q;
    dout_d = dout_q;
    if (wr) begin
      case (a)
        3'd0:    cmd_d = data_in_bus;
        3'd1:    ahi_d = data_in_bus;
        3'd2:    alo_d = data_in_bus;
        3'd4:    if (!busy) ctrl_d = data_in_bus;
        default: ;
      endcase
    end
    if (clr || start) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (state_q == DONE) done_d = 1'b1;
    if (tmo_set) tmo_d = 1'b1;
    if (rd) begin
      case (a)
        3'd0: dout_d = cmd_q;
        3'd1: dout_d = ahi_q;
        3'd2: dout_d = alo_q;
        3'd3: dout_d = {3'b000, rx_empty, tx_full,
                        tmo_q, done_q, busy};
        3'd4: dout_d = ctrl_q;
        3'd5: dout_d = {1'b0, rx_cnt_q};
        3'd6: dout_d = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
        default: dout_d = {2'b00, tx_cnt_q};
      endcase
    end
  end

  always_comb begin
    tx_wp_d  = tx_wp_q + 5'(tx_push);
    tx_rp_d  = tx_rp_q + 5'(tx_pop);
    tx_cnt_d = tx_cnt_q + 6'(tx_push) - 6'(tx_pop);
    rx_wp_d  = rx_wp_q + 6'(rx_wen);
    rx_rp_d  = rx_rp_q + 6'(rx_pop);
    rx_cnt_d = rx_cnt_q + 7'(rx_wen) - 7'(rx_pop);
    if (clr) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= data_in_bus;
    if (rx_wen)  rx_mem_q[rx_wp_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      ahi_q    <= '0;
      alo_q    <= '0;
      ctrl_q   <= '0;
      sel_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      prev_q   <= 1'b0;
      smp_q    <= 1'b0;
      tmr_q    <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      txb_q    <= '0;
      rxb_q    <= '0;
      rxn_q    <= '0;
      dout_q   <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      ahi_q    <= ahi_d;
      alo_q    <= alo_d;
      ctrl_q   <= ctrl_d;
      sel_q    <= sel_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync1_q;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      prev_q   <= line;
      smp_q    <= smp_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      txb_q    <= txb_d;
      rxb_q    <= rxb_d;
      rxn_q    <= rxn_d;
      dout_q   <= dout_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  assign data_out_bus = dout_q;

endmodule

// File: tb/tb_n64_controller_top_spec.sv
// Bench for n64_controller_top_spec: read scoreboard, joybus
// TX decoder and a model controller that answers on joy1.
module tb_n64_controller_top_spec;

  localparam int US  = 10;
  localparam int LIM = 40 * US;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] data_in_bus = '0;
  logic       write = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] data_out_bus;
  logic       ctl_drv = 1'b0;
  logic [3:0] low_seen = '0;
  logic       pend;
  wire        joy1, joy2, joy3, joy4;

  pullup (joy1);
  pullup (joy2);
  pullup (joy3);
  pullup (joy4);
  assign joy1 = ctl_drv ? 1'b0 : 1'bz;

  n64_controller_top_spec #(.CLKS_PER_US(US)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .joy1         (joy1),
    .joy2         (joy2),
    .joy3         (joy3),
    .joy4         (joy4),
    .address      (address),
    .data_in_bus  (data_in_bus),
    .write        (write),
    .ce           (ce),
    .data_out_bus (data_out_bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  string      tag_q [$];
  logic       bit_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    pend = ce && !write;
    #1;
    if (pend && exp_q.size() > 0)
      chk(tag_q.pop_front(), {24'b0, data_out_bus}, {24'b0, exp_q.pop_front()});
  end

  initial forever begin
    @(negedge joy1 or negedge joy2 or negedge joy3 or negedge joy4);
    low_seen = low_seen | ~{joy4, joy3, joy2, joy1};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a; data_in_bus = d; write = 1'b1; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e,
                    input string tg);
    exp_q.push_back(e);
    tag_q.push_back(tg);
    @(negedge clk);
    address = a; write = 1'b0; ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) bit_q.push_back(c[i]);
    bit_q.push_back(1'b1);
  endtask

  task automatic tx_decode(input int n);
    int t, lo, lo_prev;
    logic b;
    lo_prev = 0;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (joy1 !== 1'b0 && t < LIM) begin
        @(negedge clk);
        t++;
      end
      chk("tx_fall_seen", {31'b0, joy1 === 1'b0}, 1);
      if (joy1 !== 1'b0) return;
      if (i > 0) chk("tx_cell", t + lo_prev, 4 * US);
      lo = 0;
      while (joy1 === 1'b0 && lo < LIM) begin
        @(negedge clk);
        lo++;
      end
      b = bit_q.pop_front();
      chk("tx_low", lo, b ? US : 3 * US);
      lo_prev = lo;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      ctl_drv = 1'b1;
      repeat (v[i] ? US : 3 * US) @(negedge clk);
      ctl_drv = 1'b0;
      repeat (v[i] ? 3 * US : US) @(negedge clk);
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'b0, data_out_bus}, 0);
    chk("rst_joy", {28'b0, joy4, joy3, joy2, joy1}, 32'hF);
    reset_l = 1'b1;
    rd(4'd3, 8'h10, "rst_status");

    wr(4'd0, 8'h01);
    for (int i = 0; i < 32; i++) wr(4'd6, 8'h22);
    rd(4'd7, 8'h20, "tx_count32");
    wr(4'd6, 8'h99);
    rd(4'd7, 8'h20, "tx_count_full");
    rd(4'd3, 8'h18, "status_txfull");
    rd(4'd0, 8'h01, "cmd_rb");

    wr(4'd1, 8'h22);
    wr(4'd2, 8'h33);
    rd(4'd1, 8'h22, "ahi_rb");
    rd(4'd2, 8'h33, "alo_rb");
    wr(4'd1, 8'h22);
    repeat (3) @(negedge clk);
    chk("dout_hold", {24'b0, data_out_bus}, 32'h33);
    rd(4'hA, 8'h33, "alias_rb");

    low_seen = '0;
    push_bits(8'h01);
    wr(4'd4, 8'h01);
    fork
      begin
        tx_decode(9);
        repeat (3 * US) @(negedge clk);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        repeat (10 * US) @(negedge clk);
      end
      begin
        repeat (5) @(negedge clk);
        rd(4'd3, 8'h19, "status_busy");
        wr(4'd4, 8'h02);
        rd(4'd4, 8'h01, "ctrl_busy_ignored");
      end
    join
    chk("joy234_idle", {29'b0, low_seen[3:1]}, 0);
    rd(4'd3, 8'h0A, "status_done");
    rd(4'd5, 8'h04, "rx_count");
    rd(4'd6, 8'h12, "rx0");
    rd(4'd6, 8'h34, "rx1");
    rd(4'd6, 8'h56, "rx2");
    rd(4'd6, 8'h78, "rx3");
    rd(4'd6, 8'h00, "rx_empty_pop");
    rd(4'd5, 8'h00, "rx_count0");
    rd(4'd3, 8'h1A, "done_sticky");

    wr(4'd7, 8'h00);
    rd(4'd3, 8'h10, "status_clr");
    rd(4'd7, 8'h00, "tx_count_clr");

    wr(4'd0, 8'h00);
    push_bits(8'h00);
    wr(4'd4, 8'h01);
    tx_decode(9);
    repeat (60 * US) @(negedge clk);
    rd(4'd3, 8'h11, "pre_timeout");
    repeat (12 * US) @(negedge clk);
    rd(4'd3, 8'h16, "timeout");
    rd(4'd5, 8'h00, "timeout_rxcnt");

    wr(4'd0, 8'h01);
    low_seen = '0;
    wr(4'd4, 8'h0C);
    t = 0;
    while (joy3 !== 1'b0 && t < LIM) begin
      @(negedge clk);
      t++;
    end
    chk("joy3_low", {31'b0, joy3 === 1'b0}, 1);
    reset_l = 1'b0;
    #1;
    chk("rst_release", {31'b0, joy3 === 1'b1}, 1);
    chk("lowest_bit_sel", {28'b0, low_seen}, 32'h4);
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    low_seen = '0;
    repeat (10 * US) @(negedge clk);
    chk("rst_no_resume", {28'b0, low_seen}, 0);
    rd(4'd3, 8'h10, "rst2_status");
    rd(4'd4, 8'h00, "rst2_ctrl");
    rd(4'd0, 8'h00, "rst2_cmd");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
